quote_dispatcher: RTL and testbench
===================================

QUOTE_DISPATCHER -- requirements
Module: quote_dispatcher

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, price width; NUM_STOCKS, default 4, number of stock slots; FP_WORD_SIZE, default 64, Q32.32 reciprocal width; TIMEOUT_CYCLES, default 64, completion wait limit; RESET_BUFFER_SIZE, default 32, buffer size at reset.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_reset  input  1  asynchronous active-high reset.
REQ-005 i_quote_valid  input  1  top-of-book update strobe.
REQ-006 i_quote_stock_id  input  $clog2(NUM_STOCKS)  stock of the update.
REQ-007 i_quote_ask / i_quote_bid  input  DATA_WIDTH each  best ask / best bid.
REQ-008 i_cfg_we  input  1  config write strobe.
REQ-009 i_cfg_buffer_size  input  DATA_WIDTH  new buffer size; i_cfg_buffer_size_reciprocal  input  FP_WORD_SIZE  its Q32.32 reciprocal.
REQ-010 i_vol_done  input  1  completion pulse from the volatility engine.
REQ-011 o_stock_id  output  $clog2(NUM_STOCKS); o_data_valid  output  1; o_best_ask / o_best_bid  output  DATA_WIDTH: update issued to the volatility engine.
REQ-012 o_buffer_size  output  DATA_WIDTH; o_buffer_size_reciprocal  output  FP_WORD_SIZE: active configuration.
REQ-013 o_pending  output  NUM_STOCKS  per-stock pending flags; o_busy  output  1  FSM not IDLE.
REQ-014 o_drop_count  output  16  overwritten updates, saturating; o_reject  output  1  invalid quote pulse; o_timeout  output  1  wait-timeout pulse.

Function
REQ-015 Each stock SHALL have one slot: ask, bid, pending bit; accepted quotes write the slot and set pending on the next edge.
REQ-016 A quote SHALL be rejected (slot untouched, o_reject high one cycle) when ask == 0, bid == 0, or ask < bid; ask == bid is accepted.
REQ-017 An accepted quote into an already-pending slot SHALL overwrite it and increment o_drop_count, holding at 16'hFFFF.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT; IDLE -> ISSUE when any pending bit is set.
REQ-019 Selection SHALL be round-robin, searching from last issued stock + 1 modulo NUM_STOCKS; after reset the search starts at stock 0.
REQ-020 In ISSUE, o_data_valid SHALL be high exactly one cycle with the selected slot's id/ask/bid registered; the slot's pending bit clears; then -> WAIT.
REQ-021 A quote for the issued stock arriving in the ISSUE cycle SHALL leave pending set with the new data and SHALL NOT count as a drop.
REQ-022 In WAIT, i_vol_done SHALL return the FSM to IDLE next edge; a wait counter reaching TIMEOUT_CYCLES SHALL pulse o_timeout one cycle and return to IDLE.
REQ-023 i_vol_done in IDLE or ISSUE SHALL be ignored.
REQ-024 Minimum issue spacing SHALL be 3 cycles (ISSUE, WAIT with done, IDLE).
REQ-025 i_cfg_we SHALL update configuration only when the FSM is IDLE or WAIT; in ISSUE it is ignored.
REQ-026 o_best_ask/o_best_bid/o_stock_id SHALL hold their last issued values outside ISSUE.

Reset
REQ-027 On i_reset asserted, asynchronously: state IDLE, all slots and pending clear, o_data_valid 0, o_stock_id 0, prices 0, o_drop_count 0, o_reject 0, o_timeout 0, o_busy 0, o_buffer_size RESET_BUFFER_SIZE, o_buffer_size_reciprocal 64'h0000_0000_0800_0000.
REQ-028 Reset mid-WAIT SHALL discard the outstanding update; no o_timeout pulse is produced.

Verification
REQ-029 Quote stock 2 ask=105 bid=100, done 2 cycles after issue -> one o_data_valid, o_stock_id=2, ask=105, bid=100, o_pending=0.
REQ-030 Quotes on stocks 0,1,3 same cycle-sequence while idle -> issue order 0,1,3, each after prior i_vol_done.
REQ-031 Two quotes on stock 1 (100/99 then 102/101) before issue -> single issue 102/101, o_drop_count=1.
REQ-032 Quote ask=99 bid=100, then ask=0 bid=0 -> two o_reject pulses, o_pending unchanged.
REQ-033 Issue with no i_vol_done -> o_timeout pulse exactly TIMEOUT_CYCLES cycles into WAIT, next pending stock issued afterwards.
REQ-034 Assert i_reset during WAIT with stock 3 pending -> all outputs at reset values, no issue until a new quote.

Source files
------------

// File: rtl/quote_dispatcher.sv
// Quote dispatcher: per-stock top-of-book slots, round-robin issue to a
// volatility engine with done/timeout handshake and runtime buffer config.
//
// Ports:
//   i_clk, i_reset              clock, async active-high reset
//   i_quote_*                   top-of-book update (valid, stock id, ask, bid)
//   i_cfg_*                     buffer size / Q32.32 reciprocal write
//   i_vol_done                  completion pulse from the volatility engine
//   o_data_valid, o_stock_id,
//   o_best_ask, o_best_bid      update issued to the engine (held between issues)
//   o_buffer_size(_reciprocal)  active configuration
//   o_pending, o_busy           per-stock pending flags, FSM not idle
//   o_drop_count                saturating count of overwritten updates
//   o_reject, o_timeout         invalid-quote and wait-timeout pulses

module quote_dispatcher #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_STOCKS        = 4,
  parameter int FP_WORD_SIZE      = 64,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int RESET_BUFFER_SIZE = 32,
  localparam int IDW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_quote_valid,
  input  logic [IDW-1:0]          i_quote_stock_id,
  input  logic [DATA_WIDTH-1:0]   i_quote_ask,
  input  logic [DATA_WIDTH-1:0]   i_quote_bid,
  input  logic                    i_cfg_we,
  input  logic [DATA_WIDTH-1:0]   i_cfg_buffer_size,
  input  logic [FP_WORD_SIZE-1:0] i_cfg_buffer_size_reciprocal,
  input  logic                    i_vol_done,
  output logic [IDW-1:0]          o_stock_id,
  output logic                    o_data_valid,
  output logic [DATA_WIDTH-1:0]   o_best_ask,
  output logic [DATA_WIDTH-1:0]   o_best_bid,
  output logic [DATA_WIDTH-1:0]   o_buffer_size,
  output logic [FP_WORD_SIZE-1:0] o_buffer_size_reciprocal,
  output logic [NUM_STOCKS-1:0]   o_pending,
  output logic                    o_busy,
  output logic [15:0]             o_drop_count,
  output logic                    o_reject,
  output logic                    o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] ask_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] bid_q [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] pend_q;
  logic [NUM_STOCKS-1:0] pend_next;
  logic [IDW-1:0]        last_q;
  logic [IDW-1:0]        sel;
  logic [IDW-1:0]        cand;
  logic [IDW:0]          sum;
  logic                  found;
  logic [CW-1:0]         wait_q;
  logic                  accept;
  logic                  issue;
  logic                  drop;

  assign accept = i_quote_valid
               && (32'(i_quote_stock_id) < NUM_STOCKS)
               && (i_quote_ask != '0)
               && (i_quote_bid != '0)
               && (i_quote_ask >= i_quote_bid);

  // Round-robin search starting just after the last issued stock.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_STOCKS; i++) begin
      sum = {1'b0, last_q} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_STOCKS))
        sum = sum - (IDW+1)'(NUM_STOCKS);
      cand = sum[IDW-1:0];
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign issue = (state == IDLE) && found;

  // A quote landing on the stock being issued this edge replaces data that
  // was just handed out, so it is not a lost update.
  assign drop = accept
             && pend_q[i_quote_stock_id]
             && !(issue && (i_quote_stock_id == sel));

  always_comb begin
    pend_next = pend_q;
    if (issue)
      pend_next[sel] = 1'b0;
    if (accept)
      pend_next[i_quote_stock_id] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      pend_q        <= '0;
      last_q        <= IDW'(NUM_STOCKS - 1);
      wait_q        <= '0;
      o_data_valid  <= 1'b0;
      o_stock_id    <= '0;
      o_best_ask    <= '0;
      o_best_bid    <= '0;
      o_drop_count  <= '0;
      o_reject      <= 1'b0;
      o_timeout     <= 1'b0;
      o_buffer_size <= DATA_WIDTH'(RESET_BUFFER_SIZE);
      o_buffer_size_reciprocal <=
        FP_WORD_SIZE'(64'h0000_0000_0800_0000);
      for (int i = 0; i < NUM_STOCKS; i++) begin
        ask_q[i] <= '0;
        bid_q[i] <= '0;
      end
    end else begin
      o_data_valid <= 1'b0;
      o_reject     <= 1'b0;
      o_timeout    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (found) begin
            o_data_valid <= 1'b1;
            o_stock_id   <= sel;
            o_best_ask   <= ask_q[sel];
            o_best_bid   <= bid_q[sel];
            last_q       <= sel;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wait_q <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (i_vol_done) begin
            state <= IDLE;
          end else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      pend_q <= pend_next;

      if (accept) begin
        ask_q[i_quote_stock_id] <= i_quote_ask;
        bid_q[i_quote_stock_id] <= i_quote_bid;
        if (drop && (o_drop_count != 16'hFFFF))
          o_drop_count <= o_drop_count + 16'd1;
      end else if (i_quote_valid) begin
        o_reject <= 1'b1;
      end

      if (i_cfg_we && (state != ISSUE)) begin
        o_buffer_size            <= i_cfg_buffer_size;
        o_buffer_size_reciprocal <= i_cfg_buffer_size_reciprocal;
      end
    end
  end

  assign o_pending = pend_q;
  assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_quote_dispatcher.sv
// Bench for quote_dispatcher: directed quote scenarios checked every cycle
// against a behavioural model, plus literal per-scenario expectations.

module tb_quote_dispatcher;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int FW = 64;
  localparam int TO = 8;
  localparam int RB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          q_valid = 1'b0;
  logic [1:0]    q_id = '0;
  logic [DW-1:0] q_ask = '0;
  logic [DW-1:0] q_bid = '0;
  logic          cfg_we = 1'b0;
  logic [DW-1:0] cfg_size = '0;
  logic [FW-1:0] cfg_rec = '0;
  logic          vol_done = 1'b0;

  logic [1:0]    o_stock_id;
  logic          o_data_valid;
  logic [DW-1:0] o_best_ask;
  logic [DW-1:0] o_best_bid;
  logic [DW-1:0] o_buffer_size;
  logic [FW-1:0] o_buffer_size_reciprocal;
  logic [NS-1:0] o_pending;
  logic          o_busy;
  logic [15:0]   o_drop_count;
  logic          o_reject;
  logic          o_timeout;

  quote_dispatcher #(
    .DATA_WIDTH(DW), .NUM_STOCKS(NS), .FP_WORD_SIZE(FW),
    .TIMEOUT_CYCLES(TO), .RESET_BUFFER_SIZE(RB)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_quote_valid(q_valid),
    .i_quote_stock_id(q_id),
    .i_quote_ask(q_ask),
    .i_quote_bid(q_bid),
    .i_cfg_we(cfg_we),
    .i_cfg_buffer_size(cfg_size),
    .i_cfg_buffer_size_reciprocal(cfg_rec),
    .i_vol_done(vol_done),
    .o_stock_id(o_stock_id),
    .o_data_valid(o_data_valid),
    .o_best_ask(o_best_ask),
    .o_best_bid(o_best_bid),
    .o_buffer_size(o_buffer_size),
    .o_buffer_size_reciprocal(o_buffer_size_reciprocal),
    .o_pending(o_pending),
    .o_busy(o_busy),
    .o_drop_count(o_drop_count),
    .o_reject(o_reject),
    .o_timeout(o_timeout)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: slots, pending set, phase (0 idle, 1 issuing, 2 waiting)
  logic [DW-1:0] m_ask [NS];
  logic [DW-1:0] m_bid [NS];
  logic [NS-1:0] m_pend;
  int            m_last, m_phase, m_wait, m_drop;
  logic [DW-1:0] m_cfg;
  logic [FW-1:0] m_rec;
  logic          e_valid, e_reject, e_timeout;
  logic [1:0]    e_id;
  logic [DW-1:0] e_ask, e_bid;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_ask[i] = '0;
      m_bid[i] = '0;
    end
    m_pend = '0; m_last = NS - 1; m_phase = 0; m_wait = 0; m_drop = 0;
    m_cfg = RB; m_rec = 64'h0000_0000_0800_0000;
    e_valid = 0; e_reject = 0; e_timeout = 0;
    e_id = '0; e_ask = '0; e_bid = '0;
  endtask

  task automatic model_step();
    logic [NS-1:0] old_pend;
    int sel, old_phase, k, id;
    old_pend = m_pend; old_phase = m_phase; sel = -1;
    e_valid = 0; e_reject = 0; e_timeout = 0;
    if (m_phase == 0) begin
      if (old_pend != 0) begin
        for (int j = 1; j <= NS; j++) begin
          k = (m_last + j) % NS;
          if (sel < 0 && old_pend[k]) sel = k;
        end
        e_valid = 1; e_id = 2'(sel);
        e_ask = m_ask[sel]; e_bid = m_bid[sel];
        m_pend[sel] = 1'b0; m_last = sel; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_wait = 0;
    end else begin
      if (vol_done) m_phase = 0;
      else begin
        m_wait++;
        if (m_wait == TO) begin
          e_timeout = 1; m_phase = 0;
        end
      end
    end
    if (cfg_we && old_phase != 1) begin
      m_cfg = cfg_size; m_rec = cfg_rec;
    end
    if (q_valid) begin
      id = int'(q_id);
      if (q_ask != 0 && q_bid != 0 && q_ask >= q_bid) begin
        if (old_pend[id] && sel != id && m_drop < 65535) m_drop++;
        m_ask[id] = q_ask; m_bid[id] = q_bid; m_pend[id] = 1'b1;
      end else begin
        e_reject = 1;
      end
    end
  endtask

  // Observations used by the directed checks
  int iss_id[$];
  int iss_ask[$];
  int iss_bid[$];
  int rej_cnt = 0;
  int to_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      check("valid", o_data_valid, e_valid);
      check("stock_id", o_stock_id, e_id);
      check("ask", o_best_ask, e_ask);
      check("bid", o_best_bid, e_bid);
      check("pending", o_pending, m_pend);
      check("busy", o_busy, m_phase != 0);
      check("drops", o_drop_count, m_drop);
      check("reject", o_reject, e_reject);
      check("timeout", o_timeout, e_timeout);
      check("bufsize", o_buffer_size, m_cfg);
      check("recip", o_buffer_size_reciprocal, m_rec);
      if (o_data_valid) begin
        iss_id.push_back(int'(o_stock_id));
        iss_ask.push_back(int'(o_best_ask));
        iss_bid.push_back(int'(o_best_bid));
      end
      if (o_reject) rej_cnt++;
      if (o_timeout) to_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic quote(int id, int a, int b);
    q_valid = 1'b1; q_id = 2'(id); q_ask = DW'(a); q_bid = DW'(b);
    tick();
    q_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!o_data_valid && n < 40) begin
      tick();
      n++;
    end
    if (!o_data_valid) begin
      n_chk++; n_fail++;
      $display("FAIL wait_valid: got no issue expected issue within 40");
    end
  endtask

  // Answer every wait with done until cnt issues are seen and FSM is idle.
  task automatic drain(int cnt, int budget);
    int n;
    n = 0;
    while ((iss_id.size() < cnt || o_busy) && n < budget) begin
      vol_done = o_busy && !o_data_valid;
      tick();
      n++;
    end
    vol_done = 1'b0;
    if (n >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d issues expected %0d", iss_id.size(), cnt);
    end
  endtask

  initial begin
    int n;
    logic [NS-1:0] p;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_bufsize", o_buffer_size, 32);
    check("rst_recip", o_buffer_size_reciprocal, 64'h0800_0000);
    check("rst_busy", o_busy, 0);

    // Single quote, done two cycles after issue
    iss_id.delete(); iss_ask.delete(); iss_bid.delete();
    quote(2, 105, 100);
    wait_valid();
    tick(); tick();
    vol_done = 1'b1; tick(); vol_done = 1'b0;
    repeat (3) tick();
    check("t1_count", iss_id.size(), 1);
    check("t1_id", iss_id[0], 2);
    check("t1_ask", iss_ask[0], 105);
    check("t1_bid", iss_bid[0], 100);
    check("t1_pend", o_pending, 0);

    // Three stocks back to back; done held through idle/issue is ignored
    iss_id.delete(); iss_ask.delete(); iss_bid.delete();
    vol_done = 1'b1;
    quote(0, 50, 49);
    quote(1, 60, 58);
    quote(3, 70, 70);
    vol_done = 1'b0;
    drain(3, 60);
    check("t2_count", iss_id.size(), 3);
    check("t2_id0", iss_id[0], 0);
    check("t2_id1", iss_id[1], 1);
    check("t2_id2", iss_id[2], 3);
    check("t2_ask2", iss_ask[2], 70);

    // Overwrite while busy counts one drop; config ignored during issue
    iss_id.delete(); iss_ask.delete(); iss_bid.delete();
    quote(0, 10, 9);
    wait_valid();
    cfg_we = 1'b1; cfg_size = 99; cfg_rec = 64'h1;
    quote(1, 100, 99);
    cfg_we = 1'b0;
    quote(1, 102, 101);
    check("t3_cfg_ignored", o_buffer_size, 32);
    cfg_we = 1'b1; cfg_size = 64; cfg_rec = 64'h0400_0000;
    tick();
    cfg_we = 1'b0;
    drain(2, 60);
    check("t3_id", iss_id[1], 1);
    check("t3_ask", iss_ask[1], 102);
    check("t3_bid", iss_bid[1], 101);
    check("t3_drops", o_drop_count, 1);
    check("t3_cfg", o_buffer_size, 64);
    check("t3_recip", o_buffer_size_reciprocal, 64'h0400_0000);

    // Quote for the stock being issued keeps it pending, no drop
    iss_id.delete(); iss_ask.delete(); iss_bid.delete();
    quote(1, 80, 70);
    wait_valid();
    quote(1, 110, 105);
    check("t4_pend", o_pending, 4'b0010);
    check("t4_drops", o_drop_count, 1);
    drain(2, 60);
    check("t4_id1", iss_id[1], 1);
    check("t4_ask0", iss_ask[0], 80);
    check("t4_ask1", iss_ask[1], 110);

    // Invalid quotes
    rej_cnt = 0;
    p = o_pending;
    quote(2, 99, 100);
    quote(2, 0, 0);
    quote(0, 5, 0);
    tick();
    check("t5_rejects", rej_cnt, 3);
    check("t5_pend", o_pending, p);
    check("t5_busy", o_busy, 0);

    // Timeout, then the next pending stock goes out
    iss_id.delete(); iss_ask.delete(); iss_bid.delete();
    to_cnt = 0;
    quote(0, 40, 30);
    quote(3, 45, 44);
    wait_valid();
    check("t6_first", o_stock_id, 0);
    n = 0;
    while (!o_timeout && n < 40) begin
      tick();
      n++;
    end
    check("t6_to_delay", n, TO + 1);
    tick();
    check("t6_next_valid", o_data_valid, 1);
    check("t6_next_id", o_stock_id, 3);
    drain(2, 40);
    check("t6_to_count", to_cnt, 1);

    // Reset in the middle of a wait with stock 3 pending
    quote(1, 20, 10);
    quote(3, 30, 20);
    wait_valid();
    tick(); tick();
    check("t7_pend_pre", o_pending, 4'b1000);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    iss_id.delete(); iss_ask.delete(); iss_bid.delete();
    to_cnt = 0;
    repeat (20) tick();
    check("t7_no_issue", iss_id.size(), 0);
    check("t7_no_timeout", to_cnt, 0);
    check("t7_pend", o_pending, 0);
    check("t7_bufsize", o_buffer_size, 32);
    check("t7_drops", o_drop_count, 0);
    check("t7_ask", o_best_ask, 0);
    quote(2, 9, 8);
    drain(1, 30);
    check("t7_after_id", iss_id[0], 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
